// File: rtl/seq_feeder.sv
// Query/reference sequencer for the systolic alignment array: preloads each
// N-base query segment into the PE chain, streams the reference, waits for drain.
module seq_feeder #(
    parameter int BP_WIDTH   = 2,
    parameter int N          = 64,
    parameter int LOG_N      = 6,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                        clk,
    input  logic                        reset_i,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       q_len,
    input  logic [ADDR_WIDTH-1:0]       r_len,
    output logic [ADDR_WIDTH-1:0]       q_addr,
    input  logic [BP_WIDTH-1:0]         q_data,
    output logic [ADDR_WIDTH-1:0]       r_addr,
    input  logic [BP_WIDTH-1:0]         r_data,
    output logic [BP_WIDTH-1:0]         S,
    output logic                        s_update,
    output logic [BP_WIDTH-1:0]         T,
    output logic                        valid,
    output logic                        ack,
    output logic                        new_seq,
    output logic [LOG_N-1:0]            PE_end,
    input  logic                        busy,
    output logic                        done,
    output logic [ADDR_WIDTH-LOG_N-1:0] seg
);

    localparam int SEG_W = ADDR_WIDTH - LOG_N;
    localparam int IDX_W = ADDR_WIDTH + 1;
    localparam logic [LOG_N-1:0] LOAD_LAST = LOG_N'(N - 1);
    localparam logic [LOG_N-1:0] LOAD_PEN  = LOG_N'(N - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_PREF, S_LOAD, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    // Index of the top base of segment p, i.e. p*N+N-1, one bit wider than addresses.
    function automatic logic [IDX_W-1:0] seg_top(input logic [SEG_W-1:0] p);
        return {1'b0, p, {LOG_N{1'b1}}};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] mask_addr(input logic [IDX_W-1:0] idx,
                                                       input logic [ADDR_WIDTH-1:0] len);
        return (idx >= {1'b0, len}) ? '0 : ADDR_WIDTH'(idx);
    endfunction

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_qlen, r_rlen, r_k;
    logic [IDX_W-1:0]      r_top, r_lidx;
    logic [LOG_N-1:0]      r_cnt;
    logic                  r_last, r_seen, r_szero;

    logic                  w_len_zero, w_pref_last, w_go_pref;
    logic [SEG_W-1:0]      w_pref_seg;
    logic [ADDR_WIDTH-1:0] w_pref_len, w_rlen_m1;
    logic [IDX_W-1:0]      w_pref_top, w_lidx_nx, w_lidx_nx2, w_k2;
    logic [LOG_N-1:0]      w_pref_pe;

    assign w_len_zero  = (q_len == '0) || (r_len == '0);
    assign w_pref_seg  = (r_state == S_IDLE) ? '0 : seg + SEG_W'(1);
    assign w_pref_len  = (r_state == S_IDLE) ? q_len : r_qlen;
    assign w_pref_top  = seg_top(w_pref_seg);
    assign w_pref_last = (w_pref_top + IDX_W'(1)) >= {1'b0, w_pref_len};
    assign w_pref_pe   = LOG_N'(w_pref_len - ADDR_WIDTH'(1));
    assign w_go_pref   = (r_state == S_IDLE && start && !w_len_zero) ||
                         (r_state == S_DRAIN && r_seen && !busy && !r_last);
    assign w_lidx_nx   = r_lidx - IDX_W'(1);
    assign w_lidx_nx2  = r_lidx - IDX_W'(2);
    assign w_k2        = {1'b0, r_k} + IDX_W'(2);
    assign w_rlen_m1   = r_rlen - ADDR_WIDTH'(1);

    // Buffers have one-cycle registered reads, so data lines up with the strobes.
    assign S = (s_update && !r_szero) ? q_data : '0;
    assign T = valid ? r_data : '0;

    // Datapath holding registers: only meaningful once a job has been started.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            r_qlen <= q_len;
            r_rlen <= r_len;
        end
        if (w_go_pref) r_top <= w_pref_top;
        if (r_state == S_PREF)      r_lidx <= r_top;
        else if (r_state == S_LOAD) r_lidx <= w_lidx_nx;
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            q_addr   <= '0;
            r_addr   <= '0;
            s_update <= 1'b0;
            valid    <= 1'b0;
            ack      <= 1'b0;
            new_seq  <= 1'b0;
            PE_end   <= '0;
            done     <= 1'b0;
            seg      <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_last   <= 1'b0;
            r_seen   <= 1'b0;
            r_szero  <= 1'b0;
        end else begin
            new_seq  <= 1'b0;
            done     <= 1'b0;
            ack      <= 1'b0;
            s_update <= 1'b0;
            valid    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        seg <= '0;
                        if (w_len_zero) r_state <= S_DONE;
                    end
                end
                S_PREF: begin
                    r_state  <= S_LOAD;
                    s_update <= 1'b1;
                    ack      <= 1'b1;
                    r_cnt    <= '0;
                    r_szero  <= r_top >= {1'b0, r_qlen};
                    q_addr   <= mask_addr(r_top - IDX_W'(1), r_qlen);
                end
                S_LOAD: begin
                    if (r_cnt == LOAD_LAST) begin
                        r_state <= S_STREAM;
                        valid   <= 1'b1;
                        ack     <= 1'b1;
                        r_k     <= '0;
                        q_addr  <= '0;
                        r_addr  <= (r_rlen > ADDR_WIDTH'(1)) ? ADDR_WIDTH'(1) : '0;
                    end else begin
                        s_update <= 1'b1;
                        r_cnt    <= r_cnt + LOG_N'(1);
                        r_szero  <= w_lidx_nx >= {1'b0, r_qlen};
                        q_addr   <= mask_addr(w_lidx_nx2, r_qlen);
                        if (r_cnt == LOAD_PEN) r_addr <= '0;
                    end
                end
                S_STREAM: begin
                    if (busy) r_seen <= 1'b1;
                    if (r_k == w_rlen_m1) begin
                        r_state <= S_DRAIN;
                    end else begin
                        valid  <= 1'b1;
                        ack    <= 1'b1;
                        r_k    <= r_k + ADDR_WIDTH'(1);
                        r_addr <= (w_k2 >= {1'b0, r_rlen}) ? w_rlen_m1 : ADDR_WIDTH'(w_k2);
                    end
                end
                S_DRAIN: begin
                    if (busy) r_seen <= 1'b1;
                    else if (r_seen && r_last) r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // Segment entry is shared by the first start and the drain-complete path.
            if (w_go_pref) begin
                r_state <= S_PREF;
                seg     <= w_pref_seg;
                q_addr  <= mask_addr(w_pref_top, w_pref_len);
                r_last  <= w_pref_last;
                PE_end  <= w_pref_last ? w_pref_pe : '1;
                new_seq <= (w_pref_seg == '0);
                r_seen  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_feeder.sv
// Directed bench for seq_feeder: job table checked cycle-by-cycle against a
// timeline model, plus reset sequences.
module tb_seq_feeder;

    localparam int BPW  = 2;
    localparam int N    = 64;
    localparam int LOGN = 6;
    localparam int AW   = 11;
    localparam int SEGW = AW - LOGN;

    logic clk = 1'b0;
    logic reset_i, start, busy;
    logic [AW-1:0] q_len, r_len, q_addr, r_addr;
    logic [BPW-1:0] q_data, r_data, S, T;
    logic s_update, valid, ack, new_seq, done;
    logic [LOGN-1:0] PE_end;
    logic [SEGW-1:0] seg;

    seq_feeder #(.BP_WIDTH(BPW), .N(N), .LOG_N(LOGN), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_i(reset_i), .start(start), .q_len(q_len), .r_len(r_len),
        .q_addr(q_addr), .q_data(q_data), .r_addr(r_addr), .r_data(r_data),
        .S(S), .s_update(s_update), .T(T), .valid(valid), .ack(ack),
        .new_seq(new_seq), .PE_end(PE_end), .busy(busy), .done(done), .seg(seg)
    );

    always #5 clk = ~clk;

    logic [BPW-1:0] qmem [0:(1<<AW)-1];
    logic [BPW-1:0] rmem [0:(1<<AW)-1];

    always @(posedge clk) begin
        q_data <= qmem[q_addr];
        r_data <= rmem[r_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int qlen;
        int rlen;
        int bcyc;
        int exp_p;
        int exp_pe;
        int exp_done;
        bit inject;
    } job_t;

    function automatic logic [63:0] all_outs();
        return {22'd0, q_addr, r_addr, S, s_update, T, valid, ack, new_seq, PE_end, done, seg};
    endfunction

    // Expected outputs at sample t (t=0 is the cycle after start is taken).
    task automatic model(input int t, input int qlen, input int rlen, input int b, input int ptot,
                         output logic [8:0] ctl, output bit in_seg, output int segi,
                         output int pe, output int phase, output int d);
        int seglen, p, o, idx;
        logic e_ns, e_su, e_v, e_ack, e_done;
        logic [BPW-1:0] e_s, e_t;
        seglen = N + rlen + b + 2;
        p = t / seglen;
        o = t % seglen;
        {e_ns, e_su, e_v, e_ack, e_done} = '0;
        e_s = '0;
        e_t = '0;
        in_seg = 0;
        phase = 0;
        d = 0;
        segi = p;
        pe = 0;
        if (p < ptot) begin
            in_seg = 1;
            pe = (p == ptot - 1) ? (qlen - 1) % N : N - 1;
            if (o == 0) begin
                phase = 1;
                e_ns = (p == 0);
            end else if (o <= N) begin
                phase = 2;
                idx = p * N + N - 1 - (o - 1);
                e_su = 1'b1;
                e_s = (idx < qlen) ? qmem[idx] : '0;
                e_ack = (o == 1);
            end else if (o <= N + rlen) begin
                phase = 3;
                d = o - N - 1;
                e_v = 1'b1;
                e_ack = 1'b1;
                e_t = rmem[d];
            end else begin
                phase = 4;
                d = o - N - rlen - 1;
            end
        end else if (p == ptot && o == 1) begin
            e_done = 1'b1;
        end
        ctl = {e_ns, e_su, e_s, e_v, e_t, e_ack, e_done};
    endtask

    task automatic run_job(input job_t j);
        logic [8:0] ctl;
        bit in_seg;
        int segi, pe, phase, d, ptot, done_t, ns, su, pe_last, nsamp;
        ptot = (j.qlen == 0 || j.rlen == 0) ? 0 : (j.qlen + N - 1) / N;
        done_t = -1;
        ns = 0;
        su = 0;
        pe_last = -1;
        nsamp = j.exp_done + 3;
        @(negedge clk);
        q_len = AW'(j.qlen);
        r_len = AW'(j.rlen);
        start = 1'b1;
        busy = 1'b0;
        for (int t = 0; t < nsamp; t++) begin
            @(posedge clk);
            #1;
            model(t, j.qlen, j.rlen, j.bcyc, ptot, ctl, in_seg, segi, pe, phase, d);
            check("ctl", {55'd0, new_seq, s_update, S, valid, T, ack, done}, {55'd0, ctl});
            if (in_seg)
                check("seg_pe", {53'd0, seg, PE_end}, 64'(segi * (1 << LOGN) + pe));
            if (done && done_t < 0) done_t = t;
            if (new_seq) ns++;
            if (s_update) su++;
            if (phase == 1) pe_last = int'(PE_end);
            @(negedge clk);
            start = j.inject && ((phase == 3 && d == 2) || (phase == 4 && d == 1));
            q_len = AW'($urandom);
            r_len = AW'($urandom);
            busy = (phase == 4 && d < j.bcyc);
        end
        start = 1'b0;
        busy = 1'b0;
        check("done_time", 64'(done_t), 64'(j.exp_done));
        check("new_seq_count", 64'(ns), (j.exp_p > 0) ? 64'd1 : 64'd0);
        check("s_update_count", 64'(su), 64'(j.exp_p * N));
        if (j.exp_p > 0) check("pe_end_last", 64'(pe_last), 64'(j.exp_pe));
    endtask

    job_t jobs [7];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            qmem[i] = BPW'(i * 5 + i / 7);
            rmem[i] = BPW'(i * 3 + i / 5 + 1);
        end
        //          qlen rlen busy  P  pe  done inject
        jobs[0] = '{64,  10,  5,   1, 63,  82, 1'b0};
        jobs[1] = '{150, 4,   3,   3, 21, 220, 1'b0};
        jobs[2] = '{64,  10,  5,   1, 63,  82, 1'b1};
        jobs[3] = '{0,   10,  2,   0,  0,   1, 1'b0};
        jobs[4] = '{100, 0,   2,   0,  0,   1, 1'b0};
        jobs[5] = '{1,   3,   2,   1,  0,  72, 1'b0};
        jobs[6] = '{130, 1,   1,   3,  1, 205, 1'b0};

        reset_i = 1'b1;
        start = 1'b0;
        busy = 1'b0;
        q_len = '0;
        r_len = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'($urandom);
            busy = 1'($urandom);
            q_len = AW'($urandom);
            r_len = AW'($urandom);
            @(posedge clk);
            #1;
            check("reset_outs", all_outs(), 64'd0);
        end
        @(negedge clk);
        reset_i = 1'b0;
        start = 1'b0;
        busy = 1'b0;

        for (int i = 0; i < 7; i++) run_job(jobs[i]);

        // Abort in the middle of the reference stream, then restart cleanly.
        @(negedge clk);
        q_len = AW'(64);
        r_len = AW'(10);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (N + 5) @(posedge clk);
        #1;
        check("pre_abort_valid", {63'd0, valid}, 64'd1);
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        check("midrst_outs", all_outs(), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_hold", all_outs(), 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        run_job(jobs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_feeder.md
# seq_feeder

Upstream sequencer for the systolic alignment array. It fetches query and reference bases from two synchronous-read buffers and preloads each N-base query segment into the PE chain with `s_update`. It then streams the full reference with `valid`/`ack`, and waits for the array to drain before starting the next segment. It drives `new_seq` and `PE_end`, and raises `done` once every segment of the query has been scored.

## Interface
Parameters:
- `BP_WIDTH`, 2: bits per base.
- `N`, 64: PEs in the array; must be a power of two.
- `LOG_N`, 6: log2(N).
- `ADDR_WIDTH`, 11: buffer address and length width.

Ports:
- `clk` in 1: single clock; every register is updated on the rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `start` in 1: pulse that begins an alignment; sampled only in IDLE.
- `q_len` in ADDR_WIDTH: query length in bases; latched on `start`.
- `r_len` in ADDR_WIDTH: reference length in bases; latched on `start`.
- `q_addr` out ADDR_WIDTH: query buffer read address.
- `q_data` in BP_WIDTH: query buffer data, valid one cycle after `q_addr`.
- `r_addr` out ADDR_WIDTH: reference buffer read address.
- `r_data` in BP_WIDTH: reference buffer data, valid one cycle after `r_addr`.
- `S` out BP_WIDTH: query base to the array.
- `s_update` out 1: PE query-load strobe.
- `T` out BP_WIDTH: reference base to the array.
- `valid` out 1: `T` is valid.
- `ack` out 1: array start/advance handshake.
- `new_seq` out 1: one-cycle pulse marking the first segment of a new query.
- `PE_end` out LOG_N: index of the last PE that holds a real base in the current segment.
- `busy` in 1: array is computing.
- `done` out 1: one-cycle completion pulse.
- `seg` out ADDR_WIDTH-LOG_N: current segment index.

## Operation
- Segment count is P = ceil(q_len/N). Segment p covers query bases p*N .. p*N+N-1.
- States and transitions:
  - IDLE: on `start`, latch `q_len`/`r_len` and set `seg`=0. If `q_len`==0 or `r_len`==0, go to DONE; otherwise go to PREF.
  - PREF (1 cycle): `q_addr`=p*N+N-1. Assert `new_seq` only when p==0.
  - LOAD (N cycles, cycle i=0..N-1):
    - `s_update`=1, `S`=`q_data`.
    - `q_addr` decrements, so the base loaded in cycle i is query[p*N+N-1-i].
    - After N shifts, PE j holds query[p*N+j].
    - Query indices ≥ `q_len` present `S`=0.
    - `ack`=1 in cycle i=0 only.
    - In the last LOAD cycle, `r_addr`=0.
  - STREAM (`r_len` cycles, cycle k): `valid`=1, `ack`=1, `T`=`r_data` (reference[k]), `r_addr`=k+1 saturating at `r_len`-1.
  - DRAIN:
    - `valid`=0, `ack`=0, `T`=0.
    - Set the seen-busy flag when `busy`==1.
    - When seen-busy is set and `busy`==0: if p+1<P, increment `seg` and go to PREF; otherwise go to DONE.
  - DONE (1 cycle): `done`=1, then go to IDLE.
- `PE_end`: equals N-1 for full segments. For the last segment it equals (`q_len`-1) mod N. It is held stable from PREF through DRAIN.
- `start` outside IDLE is ignored. `q_len`/`r_len` changes outside IDLE have no effect.
- `S`/`T` are 0 whenever `s_update`/`valid` respectively is 0.

## Timing
- Reset values: state IDLE, all outputs 0. This includes `q_addr`, `r_addr`, `PE_end`, `seg`, `done`, `new_seq`, `ack`, `valid` and `s_update`. Reset asserted mid-operation aborts immediately with the same values; no `done` is produced.
- `start` sampled at edge c gives PREF in cycle c+1 and the first LOAD cycle at c+2. The first `valid` comes at c+2+N.
- `S` and `T` are combinational from `q_data`/`r_data`, relying on the buffers' registered one-cycle read latency.
- A `busy` pulse that arrives during STREAM counts toward seen-busy.
- `done` follows the final busy 1→0 observation by exactly 1 cycle.
- Per-segment cost is 1 + N + `r_len` + drain cycles.
- Arithmetic:
  - Addresses are ADDR_WIDTH unsigned.
  - p*N+N-1 is computed at ADDR_WIDTH+1 bits. Values ≥ `q_len` force `S`=0; `q_addr` is masked to 0 in that case.

## Test plan
- Reset: hold `reset_i`=1 for 3 cycles with random inputs → all outputs stay 0 and state is IDLE. Release, then pulse `start` with `q_len`=64, `r_len`=10 → `new_seq`=1 exactly one cycle later.
- Single full segment (N=64, `q_len`=64, `r_len`=10, buffer model with 1-cycle latency):
  - `s_update` is high for 64 cycles and `S` sequence = q[63]..q[0].
  - Then `valid` is high for 10 cycles with `T`=r[0..9].
  - `PE_end`=63.
  - Bench drives `busy` 1 for 5 cycles then 0 → `done` pulse 1 cycle after `busy` falls.
- Multi-segment (`q_len`=150, `r_len`=4):
  - 3 segments; `new_seq` only on segment 0; `seg` goes 0→1→2.
  - `PE_end` = 63, 63, 21.
  - Segment 2 `S` sequence is 42 zeros then q[149]..q[128].
- Degenerate: `start` with `q_len`=0 (and separately `r_len`=0) → `done` two cycles after `start`; no `s_update`, `valid` or `new_seq` ever asserted.
- `start` pulsed during STREAM and DRAIN → ignored; outputs match the single-segment golden trace cycle-for-cycle.
- Reset mid-STREAM at cycle 5 → all outputs 0 on the next observation. A new `start` after release restarts from segment 0 with `new_seq`=1.
